// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous single-port word RAM between the
// instruction-fetch port and the data (load/store) port.
//
// Handshake: a requester raises req and holds req plus its address/data
// stable until the cycle in which gnt=1. gnt is combinational from req in
// that same cycle, and the request is consumed on that clock edge. At most
// one grant is issued per cycle. Reads answer with rvalid exactly
// MEM_LATENCY cycles after their grant, in grant order. Stores never answer.
//
// Arbitration: data wins over fetch, except when data has already won
// MAX_DATA_STREAK times in a row while fetch was waiting. In that case
// fetch is forced through.
module mem_arbiter #(
  parameter logic [31:0] MEM_BASE        = 32'h0000_0000,
  parameter int          MEM_SIZE        = 65536,
  parameter int          MEM_LATENCY     = 1,
  parameter int          MAX_DATA_STREAK = 4,
  localparam int         AW              = $clog2(MEM_SIZE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [29:0]   if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  output logic          if_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_be,
  input  logic [29:0]   d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          d_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam logic [29:0] BASE_WORD  = MEM_BASE[31:2];
  localparam logic [30:0] SIZE_WORDS = 31'(MEM_SIZE);
  localparam logic [3:0]  STREAK_MAX = 4'(MAX_DATA_STREAK);

  // One in-flight read: who asked for it and whether it missed the window.
  typedef struct packed {
    logic valid;
    logic owner;  // 0 = fetch, 1 = data
    logic err;
  } tag_t;

  logic [29:0]            if_idx;
  logic [29:0]            d_idx;
  logic                   if_in_range;
  logic                   d_in_range;
  logic                   fetch_forced;
  logic [3:0]             streak;
  logic [3:0]             streak_next;
  tag_t                   tag_in;
  tag_t [MEM_LATENCY-1:0] tag_q;
  tag_t                   tag_out;
  logic [31:0]            resp_data;

  // Window check: the offset from the base wraps at 30 bits, so addresses
  // below the base come out as huge offsets and fail the check.
  always_comb begin
    if_idx      = if_addr - BASE_WORD;
    d_idx       = d_addr - BASE_WORD;
    if_in_range = ({1'b0, if_idx} < SIZE_WORDS);
    d_in_range  = ({1'b0, d_idx} < SIZE_WORDS);
  end

  // Fixed-priority grant: data first, unless fetch has been starved long enough.
  always_comb begin
    fetch_forced = (streak == STREAK_MAX);
    d_gnt        = !reset && d_req && !(if_req && fetch_forced);
    if_gnt       = !reset && if_req && (!d_req || fetch_forced);
  end

  // Streak counts data wins while fetch is waiting; any fetch grant or idle fetch clears it.
  always_comb begin
    streak_next = streak;
    if (!if_req || if_gnt) begin
      streak_next = 4'd0;
    end else if (d_gnt) begin
      streak_next = streak + 4'd1;
    end
  end

  // Streak register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak <= 4'd0;
    end else begin
      streak <= streak_next;
    end
  end

  // RAM strobe: only in-window grants touch the RAM; write fields come from a granted store.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'd0;
    mem_addr  = '0;
    mem_wdata = 32'd0;
    if (if_gnt) begin
      mem_en   = if_in_range;
      mem_addr = if_idx[AW-1:0];
    end else if (d_gnt) begin
      mem_en   = d_in_range;
      mem_addr = d_idx[AW-1:0];
      if (d_we) begin
        mem_we    = 1'b1;
        mem_be    = d_be;
        mem_wdata = d_wdata;
      end
    end
  end

  // Tag for the read granted this cycle; stores and idle cycles carry no tag.
  always_comb begin
    tag_in = '0;
    if (if_gnt) begin
      tag_in.valid = 1'b1;
      tag_in.owner = 1'b0;
      tag_in.err   = !if_in_range;
    end else if (d_gnt && !d_we) begin
      tag_in.valid = 1'b1;
      tag_in.owner = 1'b1;
      tag_in.err   = !d_in_range;
    end
  end

  // Tag pipeline matched to the RAM read latency; reset drops everything in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_q <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // Response routing: the last stage picks the port; out-of-window reads return zero.
  always_comb begin
    tag_out   = tag_q[MEM_LATENCY-1];
    resp_data = (tag_out.valid && !tag_out.err) ? mem_rdata : 32'd0;
    if_rvalid = tag_out.valid && !tag_out.owner;
    d_rvalid  = tag_out.valid && tag_out.owner;
    if_err    = if_rvalid && tag_out.err;
    d_err     = d_rvalid && tag_out.err;
    if_rdata  = if_rvalid ? resp_data : 32'd0;
    d_rdata   = d_rvalid ? resp_data : 32'd0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances share one stimulus stream. Instance 0
// uses read latency 1 and instance 1 uses read latency 3. Each instance has
// its own RAM behind it. A reference model holds the memory image, the grant
// rule and the expected responses per instance.
module tb_mem_arbiter;

  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam logic [29:0] BASE_W = 30'h400;
  localparam int          SIZE   = 64;
  localparam int          AW     = 6;
  localparam int          MAXS   = 4;

  typedef struct {
    int          due;
    bit          port;   // 0 = fetch, 1 = data
    logic [31:0] data;
    bit          err;
  } resp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic        if_req;
  logic [29:0] if_addr;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [29:0] d_addr;
  logic [31:0] d_wdata;

  // ---------------- per-instance outputs ----------------
  logic          if_gnt    [2];
  logic          if_rvalid [2];
  logic [31:0]   if_rdata  [2];
  logic          if_err    [2];
  logic          d_gnt     [2];
  logic          d_rvalid  [2];
  logic [31:0]   d_rdata   [2];
  logic          d_err     [2];
  logic          mem_en    [2];
  logic          mem_we    [2];
  logic [3:0]    mem_be    [2];
  logic [AW-1:0] mem_addr  [2];
  logic [31:0]   mem_wdata [2];
  logic [31:0]   mem_rdata [2];

  mem_arbiter #(.MEM_BASE(BASE), .MEM_SIZE(SIZE), .MEM_LATENCY(1), .MAX_DATA_STREAK(MAXS)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[0]),
    .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]), .if_err(if_err[0]),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]), .d_err(d_err[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_be(mem_be[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  mem_arbiter #(.MEM_BASE(BASE), .MEM_SIZE(SIZE), .MEM_LATENCY(3), .MAX_DATA_STREAK(MAXS)) dut_lat3 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[1]),
    .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]), .if_err(if_err[1]),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]), .d_err(d_err[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_be(mem_be[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  // ---------------- RAMs behind each instance ----------------
  logic [31:0] ram   [2][SIZE];
  logic [31:0] rpipe [2][3];

  assign mem_rdata[0] = rpipe[0][0];
  assign mem_rdata[1] = rpipe[1][2];

  // Synchronous RAM with byte-enable writes; idle cycles load a marker word.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_en[k] && mem_we[k]) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be[k][b]) ram[k][mem_addr[k]][8*b +: 8] <= mem_wdata[k][8*b +: 8];
        end
      end
      rpipe[k][0] <= (mem_en[k] && !mem_we[k]) ? ram[k][mem_addr[k]] : 32'hDEAD_BEEF;
      rpipe[k][1] <= rpipe[k][0];
      rpipe[k][2] <= rpipe[k][1];
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          wins = 0;
  bit          last_ef;
  bit          last_ed;
  logic [31:0] model_mem [SIZE];
  resp_t       exp_q0 [$];
  resp_t       exp_q1 [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Compare one instance's response outputs with the head of its expected queue.
  task automatic check_port(input int k);
    resp_t r;
    bit    have = 0;
    if (k == 0) begin
      if (exp_q0.size() > 0 && exp_q0[0].due == cyc) begin r = exp_q0.pop_front(); have = 1; end
    end else begin
      if (exp_q1.size() > 0 && exp_q1[0].due == cyc) begin r = exp_q1.pop_front(); have = 1; end
    end
    check($sformatf("if_rvalid[%0d]", k), 32'(if_rvalid[k]), 32'(have && !r.port));
    check($sformatf("d_rvalid[%0d]", k),  32'(d_rvalid[k]),  32'(have && r.port));
    check($sformatf("if_err[%0d]", k),    32'(if_err[k]),    32'(have && !r.port && r.err));
    check($sformatf("d_err[%0d]", k),     32'(d_err[k]),     32'(have && r.port && r.err));
    check($sformatf("if_rdata[%0d]", k),  if_rdata[k], (have && !r.port) ? r.data : 32'd0);
    check($sformatf("d_rdata[%0d]", k),   d_rdata[k],  (have && r.port) ? r.data : 32'd0);
  endtask

  // Model one cycle from the driven inputs: decide the winner, check the
  // combinational outputs, then update the memory image and response queues.
  task automatic model_cycle();
    int          fi, di;
    bit          fin, din, ef, ed, we;
    logic [31:0] e_addr;
    resp_t       r;
    fi  = int'(30'(if_addr - BASE_W));
    di  = int'(30'(d_addr - BASE_W));
    fin = (fi >= 0) && (fi < SIZE);
    din = (di >= 0) && (di < SIZE);
    if (reset) begin
      ef = 0; ed = 0; wins = 0;
      exp_q0.delete(); exp_q1.delete();
    end else begin
      ed = d_req && !(if_req && wins == MAXS);
      ef = if_req && !ed;
    end
    we     = ed && d_we;
    e_addr = ef ? 32'(fi % SIZE) : ed ? 32'(di % SIZE) : 32'd0;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("if_gnt[%0d]", k),    32'(if_gnt[k]), 32'(ef));
      check($sformatf("d_gnt[%0d]", k),     32'(d_gnt[k]),  32'(ed));
      check($sformatf("mem_en[%0d]", k),    32'(mem_en[k]), 32'((ef && fin) || (ed && din)));
      check($sformatf("mem_we[%0d]", k),    32'(mem_we[k]), 32'(we));
      check($sformatf("mem_be[%0d]", k),    32'(mem_be[k]), we ? 32'(d_be) : 32'd0);
      check($sformatf("mem_wdata[%0d]", k), mem_wdata[k],   we ? d_wdata : 32'd0);
      check($sformatf("mem_addr[%0d]", k),  32'(mem_addr[k]), e_addr);
    end
    if (we && din) begin
      for (int b = 0; b < 4; b++) begin
        if (d_be[b]) model_mem[di][8*b +: 8] = d_wdata[8*b +: 8];
      end
    end
    if (ef || (ed && !d_we)) begin
      r.port = ed;
      r.err  = ed ? !din : !fin;
      r.data = r.err ? 32'd0 : model_mem[ed ? di : fi];
      r.due  = cyc + 1; exp_q0.push_back(r);
      r.due  = cyc + 3; exp_q1.push_back(r);
    end
    if (!reset) begin
      if (!if_req || ef) wins = 0;
      else if (ed) wins++;
    end
    last_ef = ef;
    last_ed = ed;
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit rst, input bit ir, input logic [29:0] ia,
                      input bit dr, input bit dw, input logic [3:0] be,
                      input logic [29:0] da, input logic [31:0] wd);
    @(negedge clk);
    cyc++;
    check_port(0);
    check_port(1);
    reset   = rst;
    if_req  = ir;
    if_addr = ia;
    d_req   = dr;
    d_we    = dw;
    d_be    = be;
    d_addr  = da;
    d_wdata = wd;
    #1;
    model_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 30'd0, 0, 0, 4'd0, 30'd0, 32'd0);
  endtask

  function automatic logic [29:0] w(input int idx);
    return BASE_W + 30'(idx);
  endfunction

  function automatic logic [29:0] rand_addr();
    if ($urandom_range(0, 15) == 0) return BASE_W - 30'($urandom_range(1, 4));
    return BASE_W + 30'($urandom_range(0, SIZE + 3));
  endfunction

  // ---------------- stimulus ----------------
  logic [9:0]  pat;
  bit          ir, dr, dw, rst;
  logic [29:0] ia, da;
  logic [3:0]  dbe;
  logic [31:0] dwd;

  initial begin
    reset = 1'b1; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < SIZE; i++) begin
      ram[0][i]    = 32'(i + 100);
      ram[1][i]    = 32'(i + 100);
      model_mem[i] = 32'(i + 100);
    end
    for (int k = 0; k < 2; k++) for (int j = 0; j < 3; j++) rpipe[k][j] = 32'd0;

    // Power-up reset with both requesters pushing: nothing may be granted.
    step(1, 1, w(1), 1, 0, 4'd0, w(2), 32'd0);
    step(1, 1, w(1), 1, 1, 4'hF, w(2), 32'h1234_5678);
    idle(2);

    // Fetch-only reads of words 0..3 on consecutive cycles.
    for (int i = 0; i < 4; i++) step(0, 1, w(i), 0, 0, 4'd0, 30'd0, 32'd0);
    idle(4);

    // Fetch and data load held together: D,D,D,D,F,D,D,D,D,F.
    pat = '0;
    for (int i = 0; i < 10; i++) begin
      step(0, 1, w(20), 1, 0, 4'd0, w(10), 32'd0);
      pat = {pat[8:0], d_gnt[0]};
    end
    check("streak_order", 32'(pat), 32'(10'b1111011110));
    idle(4);

    // Partial store to word 5, then load it back.
    step(0, 0, 30'd0, 1, 1, 4'b0011, w(5), 32'hAABB_CCDD);
    step(0, 0, 30'd0, 1, 0, 4'd0, w(5), 32'd0);
    idle(4);
    check("store_merge", model_mem[5], 32'h0000_CCDD);

    // Out-of-window load one word past the end, one below the base, and a fetch past the end.
    step(0, 0, 30'd0, 1, 0, 4'd0, w(SIZE), 32'd0);
    step(0, 0, 30'd0, 1, 0, 4'd0, BASE_W - 30'd1, 32'd0);
    step(0, 1, w(SIZE + 2), 0, 0, 4'd0, 30'd0, 32'd0);
    step(0, 0, 30'd0, 1, 1, 4'hF, w(SIZE), 32'hFFFF_FFFF);
    idle(4);

    // Alternating F,D,F,D reads.
    step(0, 1, w(1), 0, 0, 4'd0, 30'd0, 32'd0);
    step(0, 0, 30'd0, 1, 0, 4'd0, w(2), 32'd0);
    step(0, 1, w(3), 0, 0, 4'd0, 30'd0, 32'd0);
    step(0, 0, 30'd0, 1, 0, 4'd0, w(4), 32'd0);
    idle(4);

    // Reset while two reads are in flight, then a normal read.
    step(0, 1, w(6), 0, 0, 4'd0, 30'd0, 32'd0);
    step(0, 0, 30'd0, 1, 0, 4'd0, w(7), 32'd0);
    step(1, 1, w(8), 1, 0, 4'd0, w(9), 32'd0);
    step(1, 0, 30'd0, 0, 0, 4'd0, 30'd0, 32'd0);
    idle(3);
    step(0, 1, w(8), 0, 0, 4'd0, 30'd0, 32'd0);
    idle(4);

    // Randomized traffic, holding each request until the model grants it.
    ir = 0; dr = 0; dw = 0; ia = '0; da = '0; dbe = '0; dwd = '0;
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (rst) begin
        ir = 0; dr = 0;
      end else begin
        if (!(ir && !last_ef)) begin
          ir = ($urandom_range(0, 3) != 0);
          ia = rand_addr();
        end
        if (!(dr && !last_ed)) begin
          dr  = ($urandom_range(0, 3) != 0);
          dw  = ($urandom_range(0, 2) == 0);
          dbe = 4'($urandom_range(0, 15));
          da  = rand_addr();
          dwd = $urandom;
        end
      end
      step(rst, ir, ia, dr, dw, dbe, da, dwd);
    end
    idle(5);
    check("drain", 32'(exp_q0.size() + exp_q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
